poly_negacyclic_reducer: RTL and testbench

// Downstream stage of the poly_mult_systolic_array. Takes the full (2D-1)-coefficient

---
 rtl/poly_negacyclic_reducer_pkg.sv | 20 ++
 rtl/poly_negacyclic_reducer_if.sv | 31 +++
 rtl/poly_negacyclic_reducer_barrett.sv | 40 ++++
 rtl/poly_negacyclic_reducer.sv | 117 +++++++++++
 tb/tb_poly_negacyclic_reducer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_negacyclic_reducer_pkg.sv
// Shared parameters, FSM encoding and Barrett constant helper for the
// negacyclic reducer slice.
package poly_negacyclic_reducer_pkg;

   localparam int DEF_D = 16;
   localparam int DEF_N = 16;
   localparam int DEF_Q = 12289;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // floor(2^(2n) / q); valid for n <= 31 so the shift stays inside 64 bits.
   function automatic logic [63:0] barrett_mu(input int n, input int q);
      return (64'd1 << (2 * n)) / 64'(q);
   endfunction

endpackage

// File: rtl/poly_negacyclic_reducer_if.sv
// Handshake bundle between the product source, the reducer and the consumer.
//
// Valid/ready: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds valid and its payload unchanged until that
// edge; ready may rise or fall freely. The reducer accepts p only in IDLE and
// holds r stable from the rise of out_valid until the out transfer edge.
interface poly_negacyclic_reducer_if
   import poly_negacyclic_reducer_pkg::*;
#(
   parameter int D = DEF_D,
   parameter int N = DEF_N
);
   logic                     in_valid;
   logic                     in_ready;
   logic [2*N*(2*D-1)-1:0]   p;
   logic                     out_valid;
   logic                     out_ready;
   logic [D*N-1:0]           r;
   logic                     busy;
   state_t                   state;

   modport master (
      output in_valid, p, out_ready,
      input  in_ready, out_valid, r, busy, state
   );

   modport slave (
      input  in_valid, p, out_ready,
      output in_ready, out_valid, r, busy, state
   );
endinterface

// File: rtl/poly_negacyclic_reducer_barrett.sv
// Combinational Barrett reduction of a 2N-bit unsigned value modulo Q.
// With MU = floor(2^(2N)/Q) the quotient estimate is short by at most two,
// so two conditional subtracts give the exact remainder for every input.
module barrett_reduce
   import poly_negacyclic_reducer_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int Q = DEF_Q
) (
   input  logic [2*N-1:0] x,
   output logic [N-1:0]   y
);
   localparam logic [63:0] MU64 = barrett_mu(N, Q);
   localparam logic [63:0] Q64  = 64'(Q);

   if (Q < 2 || Q64 >= (64'd1 << N)) begin : g_bad_q
      $error("barrett_reduce: Q must satisfy 2 <= Q < 2^N");
   end

   logic [2*N-1:0] mu;
   logic [2*N-1:0] qw;
   logic [4*N-1:0] prod;
   logic [2*N-1:0] qe;
   logic [2*N-1:0] t0;
   logic [2*N-1:0] t1;
   logic [2*N-1:0] t2;

   // Quotient estimate, remainder candidate, then the two correction steps.
   always_comb begin
      mu   = MU64[2*N-1:0];
      qw   = Q64[2*N-1:0];
      prod = {{(2*N){1'b0}}, x} * {{(2*N){1'b0}}, mu};
      qe   = (2*N)'(prod >> (2*N));
      t0   = x - (2*N)'(qe * qw);
      t1   = (t0 >= qw) ? t0 - qw : t0;
      t2   = (t1 >= qw) ? t1 - qw : t1;
      y    = N'(t2);
   end

endmodule

// File: rtl/poly_negacyclic_reducer.sv
// Folds a (2D-1)-coefficient linear product modulo x^D+1 and reduces each
// coefficient modulo Q, producing one output coefficient per RUN cycle.
module poly_negacyclic_reducer
   import poly_negacyclic_reducer_pkg::*;
#(
   parameter int D = DEF_D,
   parameter int N = DEF_N,
   parameter int Q = DEF_Q
) (
   input  logic                        clk,
   input  logic                        rst,
   poly_negacyclic_reducer_if.slave    bus
);
   localparam int            IW     = (D > 1) ? $clog2(D) : 1;
   localparam int            PW     = 2*N*(2*D-1);
   localparam logic [IW-1:0] LAST   = IW'(D-1);
   localparam logic [IW:0]   HI_OFF = (IW+1)'(D);
   localparam logic [N:0]    QN1    = (N+1)'(Q);

   state_t           st;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic [D*N-1:0]   r_q;
   logic [IW-1:0]    idx;
   logic [PW-1:0]    pbuf;

   logic [2*N-1:0]   coef [2*D-1];
   logic             last;
   logic [IW:0]      hi_idx;
   logic [2*N-1:0]   c_lo;
   logic [2*N-1:0]   c_hi;
   logic [N-1:0]     y_lo;
   logic [N-1:0]     y_hi;
   logic [N-1:0]     res;

   // Split the captured product into coefficients and pick c_i / c_{i+D}.
   always_comb begin
      for (int k = 0; k < 2*D-1; k++) begin
         coef[k] = pbuf[2*N*k +: 2*N];
      end
      last   = (idx == LAST);
      // Clamp the upper index at the last position so it stays in range;
      // the selected value is discarded there anyway.
      hi_idx = last ? HI_OFF : ({1'b0, idx} + HI_OFF);
      c_lo   = coef[idx];
      c_hi   = last ? '0 : coef[hi_idx];
   end

   barrett_reduce #(.N(N), .Q(Q)) u_red_lo (.x(c_lo), .y(y_lo));
   barrett_reduce #(.N(N), .Q(Q)) u_red_hi (.x(c_hi), .y(y_hi));

   // Modular subtract of two residues; adding Q first keeps the N+1-bit
   // intermediate non-negative when y_lo < y_hi.
   always_comb begin
      if (y_lo >= y_hi) begin
         res = N'({1'b0, y_lo} - {1'b0, y_hi});
      end else begin
         res = N'({1'b0, y_lo} + QN1 - {1'b0, y_hi});
      end
   end

   // Control FSM with registered handshake outputs and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         r_q         <= '0;
         idx         <= '0;
         pbuf        <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  pbuf       <= bus.p;
                  idx        <= '0;
                  st         <= ST_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_RUN: begin
               r_q[N*idx +: N] <= res;
               if (last) begin
                  st          <= ST_DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  st          <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               st          <= ST_IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.r         = r_q;
   assign bus.state     = st;

endmodule

// File: tb/tb_poly_negacyclic_reducer.sv
// Bench for poly_negacyclic_reducer at D=16, N=16, Q=12289: a driver that
// pushes the modelled result of every accepted product, a monitor that pops
// and compares on each output transfer, and directed flow-control scenarios.
module tb_poly_negacyclic_reducer;
   import poly_negacyclic_reducer_pkg::*;

   localparam int D  = 16;
   localparam int N  = 16;
   localparam int Q  = 12289;
   localparam int PW = 2*N*(2*D-1);
   localparam int RW = D*N;

   logic clk;
   logic rst;
   int   cyc;
   int   errors;
   int   checks;

   logic [RW-1:0] exp_q[$];
   int            acc_q[$];

   poly_negacyclic_reducer_if #(.D(D), .N(N)) bus ();

   poly_negacyclic_reducer #(.D(D), .N(N), .Q(Q)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference: fold modulo x^D+1 with plain % arithmetic.
   function automatic logic [RW-1:0] model(input logic [PW-1:0] pv);
      logic [RW-1:0]   res;
      longint unsigned a;
      longint unsigned b;
      longint unsigned ql;
      ql  = longint'(Q);
      res = '0;
      for (int i = 0; i < D; i++) begin
         a = longint'(pv[2*N*i +: 2*N]) % ql;
         b = (i < D-1) ? longint'(pv[2*N*(i+D) +: 2*N]) % ql : 0;
         res[N*i +: N] = N'((a + ql - b) % ql);
      end
      return res;
   endfunction

   // Driver: called at a negedge; leaves in_valid high on return.
   task automatic send(input logic [PW-1:0] pv, output int acc);
      int budget;
      budget       = 0;
      bus.p        = pv;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("accept_wait", 256'(budget < 200), 256'(1));
      exp_q.push_back(model(pv));
      @(negedge clk);
      acc = cyc;
      acc_q.push_back(acc);
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || bus.busy) && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("drain_pending", 256'(exp_q.size()), 256'(0));
      check("drain_busy", 256'(bus.busy), 256'(0));
   endtask

   // Monitor: mid low phase, after inputs driven at negedge have settled.
   logic prev_ov;
   always @(negedge clk) begin
      #2;
      if (rst) begin
         prev_ov = 1'b0;
      end else begin
         if (bus.out_valid && !prev_ov && acc_q.size() != 0) begin
            check("latency", 256'(cyc - acc_q.pop_front()), 256'(D));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 256'(exp_q.size()), 256'(1));
            end else begin
               check("result", 256'(bus.r), 256'(exp_q.pop_front()));
            end
         end
         prev_ov = bus.out_valid;
      end
   end

   logic [PW-1:0] pv;
   logic [PW-1:0] pv2;
   logic [RW-1:0] held;
   int            a1;
   int            a2;
   int            wait_n;

   initial begin
      cyc           = 0;
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.p         = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 256'(bus.in_ready), 256'(1));
      check("rst_out_valid", 256'(bus.out_valid), 256'(0));
      check("rst_busy", 256'(bus.busy), 256'(0));
      check("rst_r", 256'(bus.r), 256'(0));
      check("rst_state", 256'(bus.state), 256'(ST_IDLE));
      rst = 1'b0;
      @(negedge clk);

      // Product of two all-ones polynomials.
      for (int k = 0; k < 2*D-1; k++) begin
         pv[2*N*k +: 2*N] = (2*N)'((k < D) ? k + 1 : 2*D - 1 - k);
      end
      send(pv, a1);
      bus.in_valid = 1'b0;
      drain();
      check("t1_r0", 256'(bus.r[N*0 +: N]), 256'(12275));
      check("t1_r7", 256'(bus.r[N*7 +: N]), 256'(0));
      check("t1_r14", 256'(bus.r[N*14 +: N]), 256'(14));
      check("t1_r15", 256'(bus.r[N*15 +: N]), 256'(16));

      // All coefficients at the 2N-bit maximum.
      pv = '1;
      send(pv, a1);
      bus.in_valid = 1'b0;
      drain();
      check("t2_r0", 256'(bus.r[N*0 +: N]), 256'(0));
      check("t2_r15", 256'(bus.r[N*15 +: N]), 256'(10951));

      // Negative wrap: 5 - 7.
      pv = '0;
      pv[2*N*0 +: 2*N]  = 32'd5;
      pv[2*N*16 +: 2*N] = 32'd7;
      send(pv, a1);
      bus.in_valid = 1'b0;
      drain();
      check("t3_r0", 256'(bus.r[N*0 +: N]), 256'(12287));
      check("t3_r1", 256'(bus.r[N*1 +: N]), 256'(0));

      // Random products.
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 2*D-1; k++) begin
            pv[2*N*k +: 2*N] = (t == 0) ? 32'($urandom_range(0, 3*Q)) : 32'($urandom);
         end
         send(pv, a1);
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();

      // Back-pressure in DONE; a pulsed in_valid must not be captured.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 2*D-1; k++) pv[2*N*k +: 2*N] = 32'($urandom);
      for (int k = 0; k < 2*D-1; k++) pv2[2*N*k +: 2*N] = 32'($urandom);
      send(pv, a1);
      bus.in_valid = 1'b0;
      wait_n = 0;
      while (!bus.out_valid && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      check("t4_ov_wait", 256'(bus.out_valid), 256'(1));
      held = bus.r;
      for (int j = 0; j < 5; j++) begin
         check("t4_ov_held", 256'(bus.out_valid), 256'(1));
         check("t4_r_stable", 256'(bus.r), 256'(held));
         check("t4_in_ready", 256'(bus.in_ready), 256'(0));
         if (j == 1) begin
            bus.p        = pv2;
            bus.in_valid = 1'b1;
         end
         if (j == 3) bus.in_valid = 1'b0;
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t4_ov_drop", 256'(bus.out_valid), 256'(0));
      check("t4_state_idle", 256'(bus.state), 256'(ST_IDLE));
      check("t4_in_ready_back", 256'(bus.in_ready), 256'(1));
      repeat (3) @(negedge clk);
      check("t4_no_capture", 256'(bus.busy), 256'(0));
      check("t4_pending", 256'(exp_q.size()), 256'(0));

      // Reset while RUN is at index 6.
      for (int k = 0; k < 2*D-1; k++) pv[2*N*k +: 2*N] = 32'($urandom);
      send(pv, a1);
      bus.in_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("t5_mid_run", 256'(bus.state), 256'(ST_RUN));
      rst = 1'b1;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      check("t5_in_ready", 256'(bus.in_ready), 256'(1));
      check("t5_out_valid", 256'(bus.out_valid), 256'(0));
      check("t5_busy", 256'(bus.busy), 256'(0));
      check("t5_r", 256'(bus.r), 256'(0));
      check("t5_state", 256'(bus.state), 256'(ST_IDLE));
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2*D-1; k++) pv[2*N*k +: 2*N] = 32'($urandom);
      send(pv, a1);
      bus.in_valid = 1'b0;
      drain();

      // Back-to-back products with in_valid held and out_ready high.
      for (int k = 0; k < 2*D-1; k++) pv[2*N*k +: 2*N] = 32'($urandom);
      for (int k = 0; k < 2*D-1; k++) pv2[2*N*k +: 2*N] = 32'($urandom);
      send(pv, a1);
      send(pv2, a2);
      bus.in_valid = 1'b0;
      check("t6_spacing", 256'(a2 - a1), 256'(D + 2));
      drain();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
